fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's `fifo` block (`wr`, `data_in`, `full`) among `N` producers. Each cycle it grants at most one requester and drives the FIFO write strobe and data from that requester, never writing while `full` is high. A per-owner burst limit lets a producer stream up to `MAX_BURST` consecutive words before ownership rotates. The block sits between the producer agents and the FIFO `wr`/`data_in` pins.

## Interface
- `N`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data width; equals FIFO `data_in` width.
- `MAX_BURST`, 4: maximum consecutive grants to one owner, 1..15.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  `req[i]` high: requester i has a word on its data slice.
- `req_data`  in  N*WIDTH  requester i data in bits `[i*WIDTH +: WIDTH]`.
- `fifo_full`  in  1  connects to FIFO `full`.
- `gnt`  out  N  one-hot or zero; `gnt[i]` high means the word from requester i is written at this clock edge.
- `fifo_wr`  out  1  to FIFO `wr`; equals OR of `gnt`.
- `fifo_data_in`  out  WIDTH  to FIFO `data_in`; the granted slice, or 0 when `gnt == 0`.

## Operation
- State registers: `state` {IDLE, BURST}; `owner` (clog2(N) bits); `cnt` (4 bits).
- `next(p)`: first index in p+1, p+2, ..., p+N (mod N) whose `req` is high. It can return p itself if p is the only requester.
- Reset (`rst` high at an edge): `state` = IDLE, `owner` = N-1 (so the first search starts at 0), `cnt` = 0. While `rst` is high, `gnt`, `fifo_wr` and `fifo_data_in` are forced to 0.
- `fifo_full` high, any state: `gnt` = 0 and all registers hold. The burst count is frozen, not reset.
- IDLE, not full:
  - If `req != 0`: sel = `next(owner)`; `gnt[sel]` = 1. At the edge: `owner` <= sel, `cnt` <= 1, `state` <= BURST.
  - Otherwise: no grant; stay in IDLE.
- BURST, not full:
  - If `req[owner]` and `cnt < MAX_BURST`: grant `owner`; `cnt` <= `cnt`+1.
  - Else if `req != 0`: sel = `next(owner)`; grant sel; `owner` <= sel, `cnt` <= 1. A lone requester therefore re-wins with no idle cycle.
  - Else: no grant; `state` <= IDLE (`owner` is kept for fairness).
- Requesters may change `req` or data freely. A word counts as consumed only at an edge where its `gnt` bit is high.
- The arbiter never asserts `fifo_wr` with `fifo_full` high. Read-side behaviour of the FIFO is not affected.

## Timing
- Zero-latency Mealy grant: `gnt`, `fifo_wr` and `fifo_data_in` are combinational from `req`, `req_data`, `fifo_full`, `rst` and the registered state.
- Registers update only on the rising `clk` edge.
- Throughput: one write per cycle while any requester is active and the FIFO is not full. No bubble on ownership change or on MAX_BURST rotation.
- `fifo_full` rising: the grant is removed in that same cycle. `fifo_full` falling: granting resumes in that cycle with the frozen `owner`/`cnt`.
- Reset mid-burst: the cycle with `rst` high has no grant. The next cycle restarts arbitration from index 0.
- Simultaneous owner drop and a new request from another index: the rotation happens in the same cycle, following `next(owner)` order.
- Fairness: each persistently requesting index is granted within (N-1)*MAX_BURST cycles of non-full operation.

## Test plan
- Reset, then `req` = 4'b1111 with data 8'hA0..8'hA3 held, `fifo_full` = 0, MAX_BURST = 4 → `gnt` = 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again. `fifo_data_in` follows A0, A1, A2, A3.
- `req` = 4'b0100 only, held 10 cycles → `gnt` = 0100 for all 10 cycles; `fifo_wr` stays high with no gap after the 4th grant.
- `req` = 4'b1010, `fifo_full` high for cycles 3-5 → no grant during 3-5. Cycle 6 resumes the owner, and the burst count continues where it stopped (owner 1 gets 4 total grants, then requester 3).
- Owner 0 streaming, `req[0]` drops after 2 grants while `req[2]` rises → `gnt` moves 0001 → 0100 in the same cycle `req[0]` drops, with no idle cycle.
- `rst` asserted in the middle of owner 2's burst with all requests active → `gnt` = 0 in the reset cycle; the next cycle grants index 0.
- Drive the real `fifo` with 30 random writes and random full pressure → `fifo_wr` is never high while `full` is high. The sequence of words in the FIFO matches the scoreboard built from `gnt` and `req_data`.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter for the fifo block with a per-owner burst limit
module fifo_wr_arbiter #(
    parameter int N = 4,
    parameter int WIDTH = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic               fifo_full,
    output logic [N-1:0]       gnt,
    output logic               fifo_wr,
    output logic [WIDTH-1:0]   fifo_data_in
);
    localparam int OW = $clog2(N);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, sel, gidx;
    logic [3:0] cnt_q, cnt_d;
    logic keep, any, grant_en;
    always_comb begin
        sel = owner_q;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(owner_q) + k) % N]) sel = OW'((int'(owner_q) + k) % N);
        end
    end
    // the current owner continues only while it still requests and has burst budget left
    always_comb begin
        keep = (state_q == BURST) && req[owner_q] && (cnt_q < 4'(MAX_BURST));
        any = |req;
        grant_en = !rst && !fifo_full && (keep || any);
        gidx = keep ? owner_q : sel;
        gnt = grant_en ? (N'(1) << gidx) : '0;
        fifo_wr = grant_en;
        fifo_data_in = grant_en ? req_data[int'(gidx)*WIDTH +: WIDTH] : '0;
        state_d = fifo_full ? state_q : (any ? BURST : IDLE);
        owner_d = (fifo_full || keep || !any) ? owner_q : sel;
        cnt_d = fifo_full ? cnt_q : (keep ? cnt_q + 4'd1 : (any ? 4'd1 : cnt_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OW'(N - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
